bypass_subtractor_seq: RTL and testbench
========================================

BYPASS_SUBTRACTOR_SEQ -- requirements
Module: bypass_subtractor_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter BLOCK, default 4, bits per skip block processed per cycle; WIDTH % BLOCK == 0 is required, else elaboration error; NBLK = WIDTH/BLOCK.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands A, B, Bin valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  minuend.
REQ-008 SHALL have port B  input  WIDTH  subtrahend.
REQ-009 SHALL have port Bin  input  1  borrow-in.
REQ-010 SHALL have port out_valid  output  1  Diff/Bout valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Diff  output  WIDTH  A - B - Bin modulo 2^WIDTH.
REQ-013 SHALL have port Bout  output  1  borrow-out, 1 when A < B + Bin (unsigned).
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; one-hot or binary is implementer's choice.
REQ-016 IDLE: in_ready=1; in_valid=1 at an edge captures A, B, Bin, clears block index to 0, moves to RUN.
REQ-017 RUN: each cycle processes block[index] only, computing BLOCK difference bits and block borrow-out from the running borrow, then increments index.
REQ-018 Block borrow SHALL use skip logic: P = all bits of A ~^ B (per-bit propagate) in block; borrow_out = P ? borrow_in : block ripple borrow.
REQ-019 RUN SHALL move to DONE at the edge processing block NBLK-1; out_valid rises exactly NBLK cycles after the accepting edge (8 for defaults).
REQ-020 DONE: out_valid=1; Diff, Bout held stable while out_ready=0; out_ready=1 at an edge moves to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored, no queueing; no same-cycle DONE->accept.
REQ-022 Captured operands SHALL be unaffected by input changes after acceptance.
REQ-023 Diff SHALL hold the last delivered result in IDLE until overwritten in RUN; only out_valid qualifies it.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, index=0, in_ready=1, out_valid=0, busy=0, Diff=0, Bout=0 (and Ovf=0 when compiled in).
REQ-025 Reset during RUN or DONE SHALL discard the operation; no result is ever presented for it.
REQ-026 First acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro BYPASS_SUB_OVERFLOW_EN defined: SHALL add output port Ovf 1 bit, signed two's-complement overflow of A - B - Bin, valid with out_valid, held like Diff.
REQ-028 Macro absent: Ovf port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 A=00000002, B=00000001, Bin=0 -> Diff=00000001, Bout=0, out_valid 8 cycles after accept.
REQ-030 A=00000000, B=00000001, Bin=0 -> Diff=FFFFFFFF, Bout=1 (full-length borrow through all skip blocks).
REQ-031 A=9999999A, B=87654321, Bin=1 -> Diff=12345678, Bout=0; A=00000000, B=FFFFFFFF, Bin=1 -> Diff=00000000, Bout=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, Diff, Bout stable, in_ready=0; in_valid pulses during RUN/DONE ignored.
REQ-033 rst_n pulsed low at RUN cycle 3 -> out_valid never rises for that op; next op A=FFFFFFFF, B=FFFFFFFF, Bin=0 -> Diff=00000000, Bout=0.
REQ-034 With BYPASS_SUB_OVERFLOW_EN: A=80000000, B=00000001, Bin=0 -> Diff=7FFFFFFF, Bout=0, Ovf=1; A=00000002, B=00000001 -> Ovf=0.

Source files
------------

// File: rtl/bypass_subtractor_seq.sv
// Sequential skip-borrow subtractor: Diff = A - B - Bin, one BLOCK-bit slice per cycle.
// Define BYPASS_SUB_OVERFLOW_EN to add the signed-overflow output Ovf.
module bypass_subtractor_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef BYPASS_SUB_OVERFLOW_EN
  output logic             Ovf,
`endif
  output logic             busy
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned IdxW = (NBLK > 1) ? $clog2(NBLK) : 1;

  if (WIDTH % BLOCK != 0) begin : gen_width_check
    $error("WIDTH must be a multiple of BLOCK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic              borrow_q, borrow_d, bout_q, bout_d;
  logic [BLOCK-1:0]  blk_a, blk_b, blk_diff;
  logic              ripple_br, blk_prop, blk_bout;
`ifdef BYPASS_SUB_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  assign blk_a = a_q[idx_q*BLOCK +: BLOCK];
  assign blk_b = b_q[idx_q*BLOCK +: BLOCK];

  // Ripple borrow supplies the sum bits; the skip path bypasses it when every bit propagates.
  always_comb begin
    ripple_br = borrow_q;
    blk_diff  = '0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      blk_diff[i] = blk_a[i] ^ blk_b[i] ^ ripple_br;
      ripple_br   = (~blk_a[i] & blk_b[i]) | (~(blk_a[i] ^ blk_b[i]) & ripple_br);
    end
    blk_prop = &(blk_a ~^ blk_b);
    blk_bout = blk_prop ? borrow_q : ripple_br;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef BYPASS_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[idx_q*BLOCK +: BLOCK] = blk_diff;
        borrow_d = blk_bout;
        idx_d    = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NBLK - 1)) begin
          bout_d  = blk_bout;
          idx_d   = '0;
          state_d = StDone;
`ifdef BYPASS_SUB_OVERFLOW_EN
          // Operands of differing sign whose result sign differs from the minuend overflow.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef BYPASS_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef BYPASS_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign Diff      = diff_q;
  assign Bout      = bout_q;
`ifdef BYPASS_SUB_OVERFLOW_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bypass_subtractor_seq.sv
// Directed self-checking bench for bypass_subtractor_seq at default parameters.
module tb_bypass_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Diff;
  logic        Bout;
  logic        busy;
`ifdef BYPASS_SUB_OVERFLOW_EN
  logic        Ovf;
`endif

  int checks = 0;
  int errors = 0;

  bypass_subtractor_seq #(.WIDTH(32), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
`ifdef BYPASS_SUB_OVERFLOW_EN
    .Ovf       (Ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble the inputs to prove they were captured.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic bin);
    @(negedge clk);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    Bin = bin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    Bin = 1'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready_low", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp_d, input logic exp_b);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_diff"}, Diff, exp_d);
    check({tag, "_bout"}, 32'(Bout), 32'(exp_b));
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("pop_out_valid", 32'(out_valid), 32'd0);
    check("pop_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", Diff, 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First acceptance directly after reset release
    accept(32'h0000_0002, 32'h0000_0001, 1'b0);
    wait_result("small", 32'h0000_0001, 1'b0);
    pop();
    check("idle_diff_held", Diff, 32'h0000_0001);

    accept(32'h0000_0000, 32'h0000_0001, 1'b0);
    wait_result("full_borrow", 32'hFFFF_FFFF, 1'b1);
    pop();

    accept(32'h9999_999A, 32'h8765_4321, 1'b1);
    wait_result("mixed", 32'h1234_5678, 1'b0);
    pop();

    accept(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("wrap_bin", 32'h0000_0000, 1'b1);
    pop();

    // Backpressure with in_valid held high through RUN and DONE
    accept(32'h0000_0005, 32'h0000_0003, 1'b0);
    in_valid = 1'b1;
    A = 32'h1111_1111;
    B = 32'h0000_0001;
    wait_result("bp", 32'h0000_0002, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff", Diff, 32'h0000_0002);
      check("bp_bout", 32'(Bout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("no_same_cycle_accept_busy", 32'(busy), 32'd0);
    check("no_same_cycle_accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    check("bp_diff_after", Diff, 32'h0000_0002);

    // Reset during RUN discards the operation
    accept(32'h0000_0001, 32'h0000_0002, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", Diff, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_result("equal", 32'h0000_0000, 1'b0);
    pop();

`ifdef BYPASS_SUB_OVERFLOW_EN
    accept(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait_result("ovf_pos", 32'h7FFF_FFFF, 1'b0);
    check("ovf_set", 32'(Ovf), 32'd1);
    pop();
    accept(32'h0000_0002, 32'h0000_0001, 1'b0);
    wait_result("ovf_neg", 32'h0000_0001, 1'b0);
    check("ovf_clear", 32'(Ovf), 32'd0);
    pop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
